// File: rtl/controle_partida_if.sv
// ---------------------------------------------------------------------------
// controle_partida_if
// Bundles the signals between the turn sequencer (controle_partida) and the
// rest of the Jogao da Velha board: button decoder, board datapath and
// display.
//
//   master : the turn sequencer. It reads the button and datapath flags and
//            drives the selection, strobes and status.
//   slave  : the surrounding logic (decoder + datapath + display).
//
// Signals (direction as seen from master):
//   iniciar          in   start / restart request
//   tem_jogada       in   one-cycle pulse, a button press is available
//   jogada[3:0]      in   index of pressed button (0-8 legal)
//   celula_ocupada   in   cell (macro_sel, micro_sel) already taken
//   macro_cheio      in   board macro_sel has no free cell
//   fim_jogo         in   win/draw detected after the last write
//   macro_sel[3:0]   out  current macro board index
//   micro_sel[3:0]   out  current micro cell index
//   jogador          out  player to move (0 = X, 1 = O)
//   escreve          out  one-cycle write strobe
//   zera_tabuleiro   out  one-cycle board clear
//   jogar_macro      out  waiting for a macro board choice
//   jogar_micro      out  waiting for a micro cell choice
//   jogada_invalida  out  one-cycle pulse on a rejected move
//   timeout          out  sticky move-timer expiry flag
//   pronto           out  game over
//   db_estado[3:0]   out  state code for the hex display
// ---------------------------------------------------------------------------
interface controle_partida_if;
    logic       iniciar;
    logic       tem_jogada;
    logic [3:0] jogada;
    logic       celula_ocupada;
    logic       macro_cheio;
    logic       fim_jogo;

    logic [3:0] macro_sel;
    logic [3:0] micro_sel;
    logic       jogador;
    logic       escreve;
    logic       zera_tabuleiro;
    logic       jogar_macro;
    logic       jogar_micro;
    logic       jogada_invalida;
    logic       timeout;
    logic       pronto;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, tem_jogada, jogada, celula_ocupada, macro_cheio, fim_jogo,
        output macro_sel, micro_sel, jogador, escreve, zera_tabuleiro,
               jogar_macro, jogar_micro, jogada_invalida, timeout, pronto,
               db_estado
    );

    modport slave (
        output iniciar, tem_jogada, jogada, celula_ocupada, macro_cheio, fim_jogo,
        input  macro_sel, micro_sel, jogador, escreve, zera_tabuleiro,
               jogar_macro, jogar_micro, jogada_invalida, timeout, pronto,
               db_estado
    );
endinterface

// File: rtl/controle_partida.sv
// ---------------------------------------------------------------------------
// controle_partida
// Turn sequencer for the Jogao da Velha (ultimate tic-tac-toe) board.
// It alternates the players, forces each move into the macro board that
// matches the previous micro cell (free choice when that board is full),
// rejects occupied cells and full boards, strobes the write, enforces a
// per-move time limit and stops when the datapath reports end of game.
//
// Parameters:
//   TIMEOUT_CICLOS  clock cycles allowed per move (>= 2)
//
// Ports:
//   clock  system clock, all state on the rising edge
//   reset  asynchronous, active-low
//   bus    controle_partida_if.master (see the interface for signal list)
//
// Every output is either a register or a pure decode of the state register,
// so nothing on the datapath side sees a combinational path from its own
// flags back to the controls.
// ---------------------------------------------------------------------------
module controle_partida #(
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic               clock,
    input  logic               reset,
    controle_partida_if.master bus
);

    typedef enum logic [3:0] {
        INICIAL      = 4'h0,
        PREPARA      = 4'h1,
        ESPERA_MACRO = 4'h2,
        ESPERA_MICRO = 4'h3,
        VERIFICA     = 4'h4,
        ESCREVE      = 4'h5,
        VERIFICA_FIM = 4'h6,
        TROCA        = 4'h7,
        DECIDE       = 4'h8,
        FIM          = 4'hF
    } estado_t;

    localparam int TW = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
    // The timer reaches TIMEOUT_CICLOS-1 on the edge that leaves the last
    // allowed cycle, so expiry is detected while it still holds one less.
    localparam logic [TW-1:0] LIMITE = TW'(TIMEOUT_CICLOS - 2);

    estado_t       estado_q, estado_d;
    logic          forcado_q, forcado_d;   // DECIDE entered from TROCA
    logic [3:0]    macro_q, macro_d;
    logic [3:0]    micro_q, micro_d;
    logic          jogador_q, jogador_d;
    logic          timeout_q, timeout_d;
    logic          invalida_q, invalida_d;
    logic [TW-1:0] timer_q, timer_d;

    logic jogada_ok;
    logic expirou;

    assign jogada_ok = bus.tem_jogada && (bus.jogada <= 4'd8);
    assign expirou   = (timer_q == LIMITE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= INICIAL;
            forcado_q  <= 1'b0;
            macro_q    <= '0;
            micro_q    <= '0;
            jogador_q  <= 1'b0;
            timeout_q  <= 1'b0;
            invalida_q <= 1'b0;
            timer_q    <= '0;
        end else begin
            estado_q   <= estado_d;
            forcado_q  <= forcado_d;
            macro_q    <= macro_d;
            micro_q    <= micro_d;
            jogador_q  <= jogador_d;
            timeout_q  <= timeout_d;
            invalida_q <= invalida_d;
            timer_q    <= timer_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        estado_d   = estado_q;
        forcado_d  = 1'b0;
        macro_d    = macro_q;
        micro_d    = micro_q;
        jogador_d  = jogador_q;
        timeout_d  = timeout_q;
        invalida_d = 1'b0;
        timer_d    = timer_q;

        unique case (estado_q)
            INICIAL: begin
                if (bus.iniciar) estado_d = PREPARA;
            end

            PREPARA: begin
                jogador_d = 1'b0;
                timeout_d = 1'b0;
                macro_d   = '0;
                micro_d   = '0;
                timer_d   = '0;
                estado_d  = ESPERA_MACRO;
            end

            // Expiry has priority over a press in the same cycle: the move
            // is discarded and the player on turn is the one who timed out.
            ESPERA_MACRO: begin
                if (expirou) begin
                    timeout_d = 1'b1;
                    estado_d  = FIM;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (jogada_ok) begin
                        macro_d  = bus.jogada;
                        estado_d = DECIDE;
                    end
                end
            end

            // Shared by a free macro choice and by the forced-board check
            // after TROCA; only a free choice of a full board is an error.
            DECIDE: begin
                if (bus.macro_cheio) begin
                    invalida_d = !forcado_q;
                    estado_d   = ESPERA_MACRO;
                end else begin
                    estado_d   = ESPERA_MICRO;
                end
            end

            ESPERA_MICRO: begin
                if (expirou) begin
                    timeout_d = 1'b1;
                    estado_d  = FIM;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (jogada_ok) begin
                        micro_d  = bus.jogada;
                        estado_d = VERIFICA;
                    end
                end
            end

            VERIFICA: begin
                if (bus.celula_ocupada) begin
                    invalida_d = 1'b1;
                    estado_d   = ESPERA_MICRO;
                end else begin
                    estado_d   = ESCREVE;
                end
            end

            ESCREVE: estado_d = VERIFICA_FIM;

            VERIFICA_FIM: begin
                estado_d = bus.fim_jogo ? FIM : TROCA;
            end

            // The cell just played names the opponent's board. The timer
            // restarts here so the next player gets a full move period.
            TROCA: begin
                jogador_d = ~jogador_q;
                macro_d   = micro_q;
                timer_d   = '0;
                forcado_d = 1'b1;
                estado_d  = DECIDE;
            end

            FIM: begin
                if (bus.iniciar) estado_d = PREPARA;
            end

            default: estado_d = INICIAL;
        endcase
    end

    assign bus.macro_sel       = macro_q;
    assign bus.micro_sel       = micro_q;
    assign bus.jogador         = jogador_q;
    assign bus.timeout         = timeout_q;
    assign bus.jogada_invalida = invalida_q;
    assign bus.escreve         = (estado_q == ESCREVE);
    assign bus.zera_tabuleiro  = (estado_q == PREPARA);
    assign bus.jogar_macro     = (estado_q == ESPERA_MACRO);
    assign bus.jogar_micro     = (estado_q == ESPERA_MICRO);
    assign bus.pronto          = (estado_q == FIM);
    assign bus.db_estado       = estado_q;

endmodule

// File: doc/controle_partida.md
# controle_partida

Turn sequencer for the Jogão da Velha board. It sits between the button edge-detector/decoder and the board datapath. It alternates players and enforces the macro-board rule: the next move goes to the board matching the previous micro cell, unless that board is full. It rejects occupied cells, issues the write strobe, watches a per-move timeout and stops on end of game.

## Interface
Parameters:
- TIMEOUT_CICLOS, 5000, clock cycles allowed per move (≥2)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 forces state inicial and output reset values
- iniciar  in  1  start / restart request, sampled in inicial and fim
- tem_jogada  in  1  one-cycle pulse: a button press is available
- jogada  in  4  binary index of pressed button, valid with tem_jogada; 0–8 legal, 9–15 ignored
- celula_ocupada  in  1  datapath flag for cell (macro_sel, micro_sel), combinational
- macro_cheio  in  1  datapath flag: board macro_sel has no free cell, combinational
- fim_jogo  in  1  datapath win/draw detector, valid in verifica_fim
- macro_sel  out  4  current macro board index, reset 0
- micro_sel  out  4  current micro cell index, reset 0
- jogador  out  1  player to move (0 = X, 1 = O), reset 0
- escreve  out  1  one-cycle write strobe of jogador into (macro_sel, micro_sel), reset 0
- zera_tabuleiro  out  1  one-cycle board clear, reset 0
- jogar_macro  out  1  waiting for macro choice, reset 0
- jogar_micro  out  1  waiting for micro choice, reset 0
- jogada_invalida  out  1  one-cycle pulse on rejected move, reset 0
- timeout  out  1  sticky, set when a move timer expires, cleared in prepara, reset 0
- pronto  out  1  high in fim, reset 0
- db_estado  out  4  state code for the hex display, reset 0

## Operation
State codes: inicial 0, prepara 1, espera_macro 2, espera_micro 3, verifica 4, escreve 5, verifica_fim 6, troca 7, decide 8, fim F.

- inicial: all outputs idle. iniciar=1 → prepara.
- prepara: zera_tabuleiro=1, jogador←0, timeout←0, macro_sel←0, micro_sel←0 → espera_macro. The first move always chooses its macro board freely.
- espera_macro: jogar_macro=1.
  - tem_jogada with jogada≤8 → macro_sel←jogada → decide.
  - jogada≥9 → ignored, no pulse.
- decide: macro_cheio=1 → jogada_invalida pulse, → espera_macro. Otherwise → espera_micro.
- espera_micro: jogar_micro=1.
  - tem_jogada with jogada≤8 → micro_sel←jogada → verifica.
  - jogada≥9 → ignored.
- verifica: celula_ocupada=1 → jogada_invalida pulse, → espera_micro (macro kept). Otherwise → escreve.
- escreve: escreve=1 for exactly one cycle → verifica_fim.
- verifica_fim: datapath has updated. fim_jogo=1 → fim. Otherwise → troca.
- troca: jogador toggles; macro_sel←micro_sel; → sel_forcado check. This is one cycle: the next state is espera_micro if macro_cheio=0 for the new macro_sel, else espera_macro (free choice). The check is made in state troca+1 using the decide logic, but with no jogada_invalida pulse.
- fim: pronto=1; macro_sel, micro_sel, jogador and timeout hold. iniciar → prepara.
- Move timer:
  - Counts cycles while in espera_macro or espera_micro.
  - Cleared on entry from troca or prepara. Not cleared on an invalid-move return.
  - Reaching TIMEOUT_CICLOS−1 → timeout←1, → fim. jogador then names the player who timed out.
- tem_jogada outside the espera states is ignored, not queued.
- Asynchronous reset at any point → inicial, all outputs to reset values, timer 0.

## Timing
- Valid move latency, tem_jogada in espera_micro to escreve high: 2 cycles (verifica, then escreve).
- escreve to next jogar_* high: 4 cycles (verifica_fim, troca, check, espera).
- Outputs are registered or pure state decodes. No combinational path from inputs to outputs.
- celula_ocupada and macro_cheio must be valid in the same cycle macro_sel/micro_sel update. The datapath reads them combinationally.
- If tem_jogada and the timer expiry occur in the same cycle, timeout wins → fim, and the move is discarded.

## Test plan
- Reset low mid-game → next cycle db_estado=0, all outputs 0. Release, iniciar → zera_tabuleiro pulse, db_estado=2.
- Legal move: macro 4, micro 7 → escreve with macro_sel=4, micro_sel=7, jogador=0. Then jogador=1, macro_sel=7, jogar_micro=1 (forced).
- Occupied cell: celula_ocupada=1 on micro 7 → jogada_invalida pulse, no escreve, back to state 3, jogador unchanged.
- Forced board full: micro_sel=2 with macro_cheio=1 for board 2 → state 2 (free choice). Choosing full board 2 there → jogada_invalida and stay in 2.
- Timeout with TIMEOUT_CICLOS=10 and no press → after 9 cycles timeout=1, pronto=1, state F. Simultaneous press at expiry → still no escreve.
- fim_jogo=1 after a write → pronto=1, jogador not toggled. iniciar → new game with jogador=0.
